// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined multiplier: per-beat mode encoding
// and the fixed input-to-output latency of the pipeline.
package mult_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    localparam int MULT_LATENCY = 3;

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice. The slice loads whenever it is empty or its
// current contents leave in the same cycle, so bubbles collapse and a full
// pipeline of slices still moves one beat per cycle.
module pipe_stage
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // Ready depends only on our own valid bit and the downstream ready.
    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Slice register: payload only changes on a real transfer so it holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/pp_gen.sv
// Partial-product generator: row i is x gated by y[i], already shifted to its
// column weight, in a 2*Bitwidth wide field.
module pp_gen #(
    parameter int Bitwidth = 8
) (
    input  logic [Bitwidth-1:0]                   x,
    input  logic [Bitwidth-1:0]                   y,
    output logic [Bitwidth-1:0][2*Bitwidth-1:0]   rows
);

    generate
        for (genvar gi = 0; gi < Bitwidth; gi++) begin : g_row
            assign rows[gi] = {{Bitwidth{1'b0}}, x & {Bitwidth{y[gi]}}} << gi;
        end
    endgenerate

endmodule

// File: rtl/pp_reduction_approx2.sv
// Approximate (approx2) reduction: same even/odd row split as the exact tree,
// but rows within each group are merged with a carry-free OR instead of an
// adder. The final pp1 + (pp2 << 1) is still a true addition.
module pp_reduction_approx2 #(
    parameter int Bitwidth = 8
) (
    input  logic [Bitwidth-1:0][2*Bitwidth-1:0] rows,
    output logic [2*Bitwidth-1:0]               pp1,
    output logic [2*Bitwidth-1:0]               pp2
);

    logic [2*Bitwidth-1:0] odd_or;

    // Carry-free merge of even and odd rows.
    always_comb begin
        pp1    = '0;
        odd_or = '0;
        for (int i = 0; i < Bitwidth; i++) begin
            if ((i % 2) == 0) begin
                pp1 = pp1 | rows[i];
            end else begin
                odd_or = odd_or | rows[i];
            end
        end
        pp2 = odd_or >> 1;
    end

endmodule

// File: rtl/pp_reduction_exact.sv
// Exact reduction of the partial-product rows into two rows such that
// pp1 + (pp2 << 1) == x*y: even rows are summed into pp1, odd rows are summed
// and pre-shifted right by one (their bit 0 is always zero) into pp2.
module pp_reduction_exact #(
    parameter int Bitwidth = 8
) (
    input  logic [Bitwidth-1:0][2*Bitwidth-1:0] rows,
    output logic [2*Bitwidth-1:0]               pp1,
    output logic [2*Bitwidth-1:0]               pp2
);

    logic [2*Bitwidth-1:0] odd_sum;

    // Carry-propagating accumulation of even and odd rows.
    always_comb begin
        pp1     = '0;
        odd_sum = '0;
        for (int i = 0; i < Bitwidth; i++) begin
            if ((i % 2) == 0) begin
                pp1 = pp1 + rows[i];
            end else begin
                odd_sum = odd_sum + rows[i];
            end
        end
        pp2 = odd_sum >> 1;
    end

endmodule

// File: rtl/mult_pipe.sv
// Three-stage valid/ready multiplier. S1 captures operands, mode and tag; S2
// captures the two reduced rows chosen by the beat's mode; S3 captures the
// final sum pp1 + (pp2 << 1). Mode and tag travel with every beat.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int Bitwidth = 8,
    parameter int TAG_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Bitwidth-1:0]   x,
    input  logic [Bitwidth-1:0]   y,
    input  logic                  mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*Bitwidth-1:0] res,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_mode
);

    localparam int PW   = 2 * Bitwidth;
    localparam int S1_W = 2 * Bitwidth + 1 + TAG_W;
    localparam int S2_W = 2 * PW + 1 + TAG_W;
    localparam int S3_W = PW + 1 + TAG_W;

    // ---------------- S1: operands ----------------
    logic                s1_valid;
    logic                s2_ready;
    logic [S1_W-1:0]     s1_data;
    logic                s1_mode;
    logic [TAG_W-1:0]    s1_tag;
    logic [Bitwidth-1:0] s1_x;
    logic [Bitwidth-1:0] s1_y;

    pipe_stage #(.WIDTH(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({mode, in_tag, x, y}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign s1_mode = s1_data[S1_W-1];
    assign s1_tag  = s1_data[S1_W-2 -: TAG_W];
    assign s1_x    = s1_data[2*Bitwidth-1:Bitwidth];
    assign s1_y    = s1_data[Bitwidth-1:0];

    // ---------------- S2: reduced rows ----------------
    logic [Bitwidth-1:0][PW-1:0] rows;
    logic [PW-1:0]               exact_pp1;
    logic [PW-1:0]               exact_pp2;
    logic [PW-1:0]               approx_pp1;
    logic [PW-1:0]               approx_pp2;
    logic [PW-1:0]               pp1_sel;
    logic [PW-1:0]               pp2_sel;
    logic                        s2_valid;
    logic                        s3_ready;
    logic [S2_W-1:0]             s2_data;
    logic                        s2_mode;
    logic [TAG_W-1:0]            s2_tag;
    logic [PW-1:0]               s2_pp1;
    logic [PW-1:0]               s2_pp2;

    pp_gen #(.Bitwidth(Bitwidth)) u_pp_gen (
        .x    (s1_x),
        .y    (s1_y),
        .rows (rows)
    );

    pp_reduction_exact #(.Bitwidth(Bitwidth)) u_red_exact (
        .rows (rows),
        .pp1  (exact_pp1),
        .pp2  (exact_pp2)
    );

    pp_reduction_approx2 #(.Bitwidth(Bitwidth)) u_red_approx (
        .rows (rows),
        .pp1  (approx_pp1),
        .pp2  (approx_pp2)
    );

    // Each beat picks its own reduction tree, so modes never bleed across beats.
    assign pp1_sel = (mode_e'(s1_mode) == MODE_APPROX) ? approx_pp1 : exact_pp1;
    assign pp2_sel = (mode_e'(s1_mode) == MODE_APPROX) ? approx_pp2 : exact_pp2;

    pipe_stage #(.WIDTH(S2_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   ({s1_mode, s1_tag, pp1_sel, pp2_sel}),
        .out_valid (s2_valid),
        .out_ready (s3_ready),
        .out_data  (s2_data)
    );

    assign s2_mode = s2_data[S2_W-1];
    assign s2_tag  = s2_data[S2_W-2 -: TAG_W];
    assign s2_pp1  = s2_data[2*PW-1:PW];
    assign s2_pp2  = s2_data[PW-1:0];

    // ---------------- S3: final sum ----------------
    logic [PW-1:0]   sum;
    logic [S3_W-1:0] s3_data;

    // Sum is evaluated in PW bits, so anything above 2*Bitwidth is dropped.
    assign sum = s2_pp1 + (s2_pp2 << 1);

    pipe_stage #(.WIDTH(S3_W)) u_s3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s2_valid),
        .in_ready  (s3_ready),
        .in_data   ({s2_mode, s2_tag, sum}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s3_data)
    );

    assign out_mode = s3_data[S3_W-1];
    assign out_tag  = s3_data[S3_W-2 -: TAG_W];
    assign res      = s3_data[PW-1:0];

endmodule
